// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: two-master to one-slave AXI read-channel arbiter.
// One burst is outstanding at a time. Simultaneous requests go round-robin.
// R beats return to the granted master until the last beat is accepted.
module easyaxi_rd_arb #(
    parameter int unsigned AR_W = 54,
    parameter int unsigned R_W  = 40
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_arvalid,
    output logic            m0_arready,
    input  logic [AR_W-1:0] m0_ar_pld,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    output logic [R_W-1:0]  m0_r_pld,
    output logic            m0_rlast,

    input  logic            m1_arvalid,
    output logic            m1_arready,
    input  logic [AR_W-1:0] m1_ar_pld,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    output logic [R_W-1:0]  m1_r_pld,
    output logic            m1_rlast,

    output logic            s_arvalid,
    input  logic            s_arready,
    output logic [AR_W-1:0] s_ar_pld,
    input  logic            s_rvalid,
    output logic            s_rready,
    input  logic [R_W-1:0]  s_r_pld,
    input  logic            s_rlast,

    output logic            busy,
    output logic            gnt_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state;
    logic            rr_ptr;

    logic            sel_arvalid;
    logic [AR_W-1:0] sel_ar_pld;
    logic            sel_rready;

    // Granted-master selects, steered only by the registered grant
    assign sel_arvalid = gnt_idx ? m1_arvalid : m0_arvalid;
    assign sel_ar_pld  = gnt_idx ? m1_ar_pld  : m0_ar_pld;
    assign sel_rready  = gnt_idx ? m1_rready  : m0_rready;

    assign busy = (state != IDLE);

    // Arbitration FSM: grant, address handshake, data burst until rlast
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_idx <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        gnt_idx <= (m0_arvalid && m1_arvalid) ? rr_ptr : m1_arvalid;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (sel_arvalid && s_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && sel_rready && s_rlast) begin
                        state  <= IDLE;
                        rr_ptr <= ~gnt_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake routing: only the phase-active channel of the granted master passes
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_r_pld   = '0;
        m1_r_pld   = '0;
        m0_rlast   = 1'b0;
        m1_rlast   = 1'b0;
        s_arvalid  = 1'b0;
        s_ar_pld   = '0;
        s_rready   = 1'b0;
        case (state)
            ADDR: begin
                s_arvalid = sel_arvalid;
                s_ar_pld  = sel_ar_pld;
                if (gnt_idx) begin
                    m1_arready = s_arready;
                end else begin
                    m0_arready = s_arready;
                end
            end
            DATA: begin
                s_rready = sel_rready;
                if (gnt_idx) begin
                    m1_rvalid = s_rvalid;
                    m1_r_pld  = s_r_pld;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_r_pld  = s_r_pld;
                    m0_rlast  = s_rlast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Bench for easyaxi_rd_arb: master/slave models plus an R-beat scoreboard.
module tb_easyaxi_rd_arb;

    localparam int unsigned AR_W = 54;
    localparam int unsigned R_W  = 40;

    typedef struct packed {
        logic           idx;
        logic [R_W-1:0] pld;
        logic           last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [AR_W-1:0] m0_ar_pld;
    logic [R_W-1:0]  m0_r_pld;
    logic            m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [AR_W-1:0] m1_ar_pld;
    logic [R_W-1:0]  m1_r_pld;
    logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [AR_W-1:0] s_ar_pld;
    logic [R_W-1:0]  s_r_pld;
    logic            busy, gnt_idx;

    easyaxi_rd_arb #(.AR_W(AR_W), .R_W(R_W)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar_pld(m0_ar_pld),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r_pld(m0_r_pld), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar_pld(m1_ar_pld),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r_pld(m1_r_pld), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar_pld(s_ar_pld),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r_pld(s_r_pld), .s_rlast(s_rlast),
        .busy(busy), .gnt_idx(gnt_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    beat_t sb[$];

    // master model state
    int         req_left [2];
    logic [7:0] base     [2];
    logic [7:0] len      [2];
    int         rise_cyc [2];
    logic       rr_toggle;

    // slave model state
    logic       r_active, stray;
    logic [7:0] r_base, r_len, r_beat, cap_base, cap_len;
    int         stall_left;

    // sampled handshakes and monitor flags
    logic ar_hs0, ar_hs1, s_ar_hs, s_r_hs, sav, prev_sav;
    logic chk_lat, chk_gap, gap_armed;
    int   last_cyc, gap_n, m0_rv_cnt, m1_hs_cnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [AR_W-1:0] mk_ar(input logic [7:0] b, input logic [7:0] l);
        logic [AR_W-1:0] v;
        v = '0;
        v[7:0] = b;
        v[15:8] = l;
        v[AR_W-1 -: 6] = 6'h2B;
        return v;
    endfunction

    function automatic logic [R_W-1:0] mk_r(input logic [7:0] d);
        logic [R_W-1:0] v;
        v = '0;
        v[7:0] = d;
        v[R_W-1 -: 8] = 8'hA5;
        return v;
    endfunction

    task automatic push_burst(input logic idx, input logic [7:0] b, input logic [7:0] l);
        beat_t e;
        for (int i = 0; i <= int'(l); i++) begin
            e.idx  = idx;
            e.pld  = mk_r(8'(b + 8'(i)));
            e.last = (i == int'(l));
            sb.push_back(e);
        end
    endtask

    task automatic got_beat(input logic idx, input logic [R_W-1:0] pld, input logic last);
        beat_t e;
        if (sb.size() == 0) begin
            chk("sb_extra_beat", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk("r_idx", 64'(idx), 64'(e.idx));
            chk("r_pld", 64'(pld), 64'(e.pld));
            chk("r_last", 64'(last), 64'(e.last));
        end
    endtask

    // observe DUT at negedge, when all inputs and combinational paths are settled
    task automatic sample();
        ar_hs0  = m0_arvalid & m0_arready;
        ar_hs1  = m1_arvalid & m1_arready;
        s_ar_hs = s_arvalid & s_arready;
        s_r_hs  = s_rvalid & s_rready;
        sav     = s_arvalid;
        if (s_ar_hs) begin
            cap_base = s_ar_pld[7:0];
            cap_len  = s_ar_pld[15:8];
            chk("busy_addr", 64'(busy), 64'd1);
            if (sb.size() > 0) chk("gnt", 64'(gnt_idx), 64'(sb[0].idx));
        end
        if (s_arvalid && !s_arready) chk("arready_hold", 64'(m0_arready | m1_arready), 64'd0);
        if (s_arvalid && !prev_sav) begin
            if (chk_lat) begin
                chk("ar_lat", 64'(cyc - rise_cyc[1]), 64'd1);
                chk_lat = 1'b0;
            end
            if (chk_gap && gap_armed) begin
                chk("gap", 64'(cyc - last_cyc), 64'd2);
                gap_armed = 1'b0;
                gap_n++;
            end
        end
        prev_sav = s_arvalid;
        if (s_r_hs && s_rlast) begin
            last_cyc  = cyc;
            gap_armed = 1'b1;
        end
        if (m0_rvalid && !m0_rready && r_active)
            chk("r_hold", 64'(m0_r_pld), 64'(mk_r(8'(r_base + r_beat))));
        if (m0_rvalid) m0_rv_cnt++;
        if (m1_rvalid && m1_rready) m1_hs_cnt++;
        if (m0_rvalid && m0_rready) got_beat(1'b0, m0_r_pld, m0_rlast);
        if (m1_rvalid && m1_rready) got_beat(1'b1, m1_r_pld, m1_rlast);
    endtask

    // update models just after the edge at which sampled handshakes completed
    task automatic drive();
        logic av;
        if (rst) begin
            r_active = 1'b0;
        end else begin
            if (s_ar_hs) begin
                r_active = 1'b1;
                r_base   = cap_base;
                r_len    = cap_len;
                r_beat   = 8'd0;
            end else if (s_r_hs && r_active) begin
                if (r_beat == r_len) r_active = 1'b0;
                else r_beat = r_beat + 8'd1;
            end
            if (ar_hs0) begin req_left[0]--; base[0] = base[0] + 8'h20; end
            if (ar_hs1) begin req_left[1]--; base[1] = base[1] + 8'h20; end
        end
        if (sav && stall_left > 0) stall_left--;
        s_arready = (stall_left == 0);
        s_rvalid  = r_active | stray;
        s_r_pld   = r_active ? mk_r(8'(r_base + r_beat)) : (stray ? mk_r(8'h77) : '0);
        s_rlast   = r_active ? (r_beat == r_len) : stray;
        av = (req_left[0] > 0);
        if (av && !m0_arvalid) rise_cyc[0] = cyc;
        m0_arvalid = av;
        m0_ar_pld  = mk_ar(base[0], len[0]);
        av = (req_left[1] > 0);
        if (av && !m1_arvalid) rise_cyc[1] = cyc;
        m1_arvalid = av;
        m1_ar_pld  = mk_ar(base[1], len[1]);
        m0_rready  = rr_toggle ? ~m0_rready : 1'b1;
        m1_rready  = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
            drive();
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || req_left[0] != 0 || req_left[1] != 0 || busy) && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_left[0] = 1; base[0] = 8'h00; len[0] = 8'd1;
        req_left[1] = 1; base[1] = 8'h40; len[1] = 8'd1;
        rise_cyc[0] = 0; rise_cyc[1] = 0;
        rr_toggle = 1'b0; stray = 1'b0; r_active = 1'b0;
        r_base = '0; r_len = '0; r_beat = '0; cap_base = '0; cap_len = '0;
        stall_left = 0;
        ar_hs0 = 1'b0; ar_hs1 = 1'b0; s_ar_hs = 1'b0; s_r_hs = 1'b0; sav = 1'b0; prev_sav = 1'b0;
        chk_lat = 1'b0; chk_gap = 1'b0; gap_armed = 1'b0;
        last_cyc = 0; gap_n = 0; m0_rv_cnt = 0; m1_hs_cnt = 0;
        m0_arvalid = 1'b0; m0_ar_pld = '0; m0_rready = 1'b1;
        m1_arvalid = 1'b0; m1_ar_pld = '0; m1_rready = 1'b1;
        s_arready = 1'b1; s_rvalid = 1'b0; s_r_pld = '0; s_rlast = 1'b0;

        // reset hold with both masters requesting
        @(posedge clk);
        repeat (3) begin
            step();
            chk("rst_ctl", 64'({m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast,
                               s_arvalid, s_rready, busy, gnt_idx}), 64'd0);
            chk("rst_pld", 64'((|m0_r_pld) | (|m1_r_pld) | (|s_ar_pld)), 64'd0);
        end
        push_burst(1'b0, 8'h00, 8'd1);
        push_burst(1'b1, 8'h40, 8'd1);
        rst = 1'b0;
        wait_done("reset_first");

        // single master m1, four beats
        step();
        m0_rv_cnt = 0;
        chk_lat = 1'b1;
        base[1] = 8'h10; len[1] = 8'd3;
        push_burst(1'b1, 8'h10, 8'd3);
        req_left[1] = 1;
        wait_done("single");
        chk("lat_seen", 64'(chk_lat), 64'd0);
        chk("m0_quiet", 64'(m0_rv_cnt), 64'd0);

        // contention: both hold arvalid for two bursts each
        step();
        chk_gap = 1'b1; gap_armed = 1'b0; gap_n = 0;
        base[0] = 8'h80; len[0] = 8'd1;
        base[1] = 8'hC0; len[1] = 8'd1;
        push_burst(1'b0, 8'h80, 8'd1);
        push_burst(1'b1, 8'hC0, 8'd1);
        push_burst(1'b0, 8'hA0, 8'd1);
        push_burst(1'b1, 8'hE0, 8'd1);
        req_left[0] = 2; req_left[1] = 2;
        wait_done("contend");
        chk("gap_count", 64'(gap_n), 64'd3);
        chk_gap = 1'b0;

        // backpressure: slave stalls AR, m0 toggles rready
        step();
        stall_left = 5;
        rr_toggle = 1'b1;
        base[0] = 8'h30; len[0] = 8'd3;
        push_burst(1'b0, 8'h30, 8'd3);
        step();
        req_left[0] = 1;
        wait_done("backpress");
        rr_toggle = 1'b0;

        // reset in the middle of an m1 burst
        step();
        m1_hs_cnt = 0;
        base[1] = 8'h50; len[1] = 8'd3;
        push_burst(1'b1, 8'h50, 8'd3);
        req_left[1] = 1;
        for (int n = 0; n < 200 && m1_hs_cnt < 2; n++) step();
        chk("mid_beats", 64'(m1_hs_cnt), 64'd2);
        rst = 1'b1;
        step();
        sb.delete();
        req_left[0] = 0; req_left[1] = 0;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_valids", 64'({m0_rvalid, m1_rvalid, s_arvalid, s_rready, m0_arready, m1_arready}), 64'd0);
        rst = 1'b0;
        base[0] = 8'h60; len[0] = 8'd0;
        base[1] = 8'h70; len[1] = 8'd0;
        push_burst(1'b0, 8'h60, 8'd0);
        push_burst(1'b1, 8'h70, 8'd0);
        req_left[0] = 1; req_left[1] = 1;
        wait_done("rr_after_rst");

        // stray R beats while idle
        step();
        stray = 1'b1;
        step();
        repeat (3) begin
            step();
            chk("stray_rready", 64'(s_rready), 64'd0);
            chk("stray_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
            chk("stray_pld", 64'(m0_r_pld | m1_r_pld), 64'd0);
        end
        stray = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=%0d exp=done", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
